// File: rtl/oflow_mem_arbiter_ctrl.sv
// Arbiter/controller for the dual-port feature memory: round-robin write-pair vs read
// arbitration, registered active-low memory pins, frame fill tracking, fixed-latency reads.
module oflow_mem_arbiter_ctrl #(
  parameter int unsigned DATA_WIDTH_MEM = 290,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned RD_LAT         = 1
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic                      frame_clear,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH_MEM-1:0] wr_data_0,
  input  logic [DATA_WIDTH_MEM-1:0] wr_data_1,
  input  logic                      wr_last,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_rsp_valid,
  output logic [DATA_WIDTH_MEM-1:0] rd_rsp_data,
  output logic                      rd_rsp_oob,
  output logic [ADDR_WIDTH:0]       wr_count,
  output logic                      frame_done,
  output logic [ADDR_WIDTH-1:0]     mem_address_0,
  output logic [ADDR_WIDTH-1:0]     mem_address_1,
  output logic [DATA_WIDTH_MEM-1:0] mem_data_in_0,
  output logic [DATA_WIDTH_MEM-1:0] mem_data_in_1,
  output logic                      mem_csb_0,
  output logic                      mem_web_0,
  output logic                      mem_oeb_0,
  output logic                      mem_csb_1,
  output logic                      mem_web_1,
  output logic                      mem_oeb_1,
  input  logic [DATA_WIDTH_MEM-1:0] mem_data_out_0
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned PL = RD_LAT + 1;
  localparam logic [CW-1:0] WR_LIMIT  = CW'(RAM_DEPTH - 2);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(RAM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_FULL} state_e;
  typedef enum logic {G_READ, G_WRITE} grant_e;

  state_e                    state_q, state_d;
  grant_e                    last_grant_q, last_grant_d;
  logic [CW-1:0]             wr_count_q, wr_count_d;
  logic [ADDR_WIDTH-1:0]     mem_address_0_q, mem_address_0_d;
  logic [ADDR_WIDTH-1:0]     mem_address_1_q, mem_address_1_d;
  logic [DATA_WIDTH_MEM-1:0] mem_data_in_0_q, mem_data_in_0_d;
  logic [DATA_WIDTH_MEM-1:0] mem_data_in_1_q, mem_data_in_1_d;
  logic                      mem_csb_0_q, mem_csb_0_d, mem_web_0_q, mem_web_0_d;
  logic                      mem_oeb_0_q, mem_oeb_0_d, mem_csb_1_q, mem_csb_1_d;
  logic                      mem_web_1_q, mem_web_1_d, mem_oeb_1_q, mem_oeb_1_d;
  logic [PL-1:0]             rd_pipe_q, rd_pipe_d;
  logic [PL-1:0]             oob_pipe_q, oob_pipe_d;
  logic                      rd_rsp_valid_q, rd_rsp_valid_d;
  logic [DATA_WIDTH_MEM-1:0] rd_rsp_data_q, rd_rsp_data_d;
  logic                      rd_rsp_oob_q, rd_rsp_oob_d;
  logic                      frame_done_q, frame_done_d;

  logic wr_elig, wr_req, rd_req, wr_gnt, rd_gnt;

  // Round-robin grant; frame_clear suppresses all grants in its cycle
  always_comb begin
    wr_elig = ((state_q == S_IDLE) || (state_q == S_FILL)) && (wr_count_q <= WR_LIMIT);
    wr_req  = wr_valid && wr_elig && !frame_clear;
    rd_req  = rd_valid && !frame_clear;
    wr_gnt  = wr_req && (!rd_req || (last_grant_q == G_READ));
    rd_gnt  = rd_req && !wr_gnt;
  end

  assign wr_ready = wr_gnt;
  assign rd_ready = rd_gnt;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    wr_count_d      = wr_count_q;
    mem_address_0_d = '0;
    mem_address_1_d = '0;
    mem_data_in_0_d = '0;
    mem_data_in_1_d = '0;
    mem_csb_0_d     = 1'b1;
    mem_web_0_d     = 1'b1;
    mem_oeb_0_d     = 1'b1;
    mem_csb_1_d     = 1'b1;
    mem_web_1_d     = 1'b1;
    mem_oeb_1_d     = 1'b1;
    rd_pipe_d       = {rd_pipe_q[PL-2:0], rd_gnt};
    oob_pipe_d      = {oob_pipe_q[PL-2:0], (CW'(rd_addr) >= wr_count_q)};
    rd_rsp_valid_d  = rd_pipe_q[PL-1];
    rd_rsp_data_d   = rd_rsp_data_q;
    rd_rsp_oob_d    = 1'b0;

    // Memory data is valid in the last pipeline stage
    if (rd_pipe_q[PL-1]) begin
      rd_rsp_data_d = mem_data_out_0;
      rd_rsp_oob_d  = oob_pipe_q[PL-1];
    end

    if (wr_gnt) begin
      last_grant_d    = G_WRITE;
      wr_count_d      = wr_count_q + CW'(2);
      mem_address_0_d = wr_count_q[ADDR_WIDTH-1:0];
      mem_address_1_d = wr_count_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
      mem_data_in_0_d = wr_data_0;
      mem_data_in_1_d = wr_data_1;
      mem_csb_0_d     = 1'b0;
      mem_web_0_d     = 1'b0;
      mem_csb_1_d     = 1'b0;
      mem_web_1_d     = 1'b0;
      if (state_q == S_IDLE) begin
        state_d = S_FILL;
      end else if (wr_last) begin
        state_d = S_DONE;
      end else if ((wr_count_q + CW'(2)) == DEPTH_CNT) begin
        state_d = S_FULL;
      end
    end

    if (rd_gnt) begin
      last_grant_d    = G_READ;
      mem_address_0_d = rd_addr;
      mem_csb_0_d     = 1'b0;
      mem_oeb_0_d     = 1'b0;
    end

    if (frame_clear) begin
      state_d    = S_IDLE;
      wr_count_d = '0;
    end

    frame_done_d = (state_d == S_DONE) || (state_d == S_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q         <= S_IDLE;
      last_grant_q    <= G_READ;
      wr_count_q      <= '0;
      mem_address_0_q <= '0;
      mem_address_1_q <= '0;
      mem_data_in_0_q <= '0;
      mem_data_in_1_q <= '0;
      mem_csb_0_q     <= 1'b1;
      mem_web_0_q     <= 1'b1;
      mem_oeb_0_q     <= 1'b1;
      mem_csb_1_q     <= 1'b1;
      mem_web_1_q     <= 1'b1;
      mem_oeb_1_q     <= 1'b1;
      rd_pipe_q       <= '0;
      oob_pipe_q      <= '0;
      rd_rsp_valid_q  <= 1'b0;
      rd_rsp_data_q   <= '0;
      rd_rsp_oob_q    <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      wr_count_q      <= wr_count_d;
      mem_address_0_q <= mem_address_0_d;
      mem_address_1_q <= mem_address_1_d;
      mem_data_in_0_q <= mem_data_in_0_d;
      mem_data_in_1_q <= mem_data_in_1_d;
      mem_csb_0_q     <= mem_csb_0_d;
      mem_web_0_q     <= mem_web_0_d;
      mem_oeb_0_q     <= mem_oeb_0_d;
      mem_csb_1_q     <= mem_csb_1_d;
      mem_web_1_q     <= mem_web_1_d;
      mem_oeb_1_q     <= mem_oeb_1_d;
      rd_pipe_q       <= rd_pipe_d;
      oob_pipe_q      <= oob_pipe_d;
      rd_rsp_valid_q  <= rd_rsp_valid_d;
      rd_rsp_data_q   <= rd_rsp_data_d;
      rd_rsp_oob_q    <= rd_rsp_oob_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign wr_count      = wr_count_q;
  assign frame_done    = frame_done_q;
  assign mem_address_0 = mem_address_0_q;
  assign mem_address_1 = mem_address_1_q;
  assign mem_data_in_0 = mem_data_in_0_q;
  assign mem_data_in_1 = mem_data_in_1_q;
  assign mem_csb_0     = mem_csb_0_q;
  assign mem_web_0     = mem_web_0_q;
  assign mem_oeb_0     = mem_oeb_0_q;
  assign mem_csb_1     = mem_csb_1_q;
  assign mem_web_1     = mem_web_1_q;
  assign mem_oeb_1     = mem_oeb_1_q;
  assign rd_rsp_valid  = rd_rsp_valid_q;
  assign rd_rsp_data   = rd_rsp_data_q;
  assign rd_rsp_oob    = rd_rsp_oob_q;

endmodule
